// File: rtl/ternary_trit_capture.sv
// Settles, decodes and queues 3-trit binary-coded-ternary result words (A[5:4], B[3:2], C[1:0]).
// Each stable bus window yields one capture; illegal words are counted, full-FIFO drops are flagged.
module ternary_trit_capture #(
    parameter int SETTLE_CYCLES = 4,
    parameter int FIFO_DEPTH    = 4
) (
    input  logic       clk,
    input  logic       rst_n,
    input  logic       en,
    input  logic [5:0] trits_in,
    output logic       m_valid,
    input  logic       m_ready,
    output logic [4:0] m_value,
    output logic [5:0] m_raw,
    output logic [4:0] fifo_level,
    output logic [7:0] err_count,
    output logic       overflow,
    output logic [1:0] state_dbg
);

    typedef enum logic [1:0] {
        IDLE    = 2'd0,
        SETTLE  = 2'd1,
        CAPTURE = 2'd2,
        HOLD    = 2'd3
    } state_t;

    localparam int         PW          = (FIFO_DEPTH > 1) ? $clog2(FIFO_DEPTH) : 1;
    localparam logic [3:0] SETTLE_LAST = 4'(SETTLE_CYCLES);
    localparam logic [4:0] LEVEL_FULL  = 5'(FIFO_DEPTH);

    state_t          state;
    logic [5:0]      s_q;
    logic [3:0]      stable_cnt;
    logic [3:0]      cnt_inc;
    logic [PW-1:0]   wr_ptr;
    logic [PW-1:0]   rd_ptr;
    logic [4:0]      level;
    logic [5:0]      mem_raw [FIFO_DEPTH];
    logic [4:0]      mem_val [FIFO_DEPTH];

    logic [1:0]      ta, tb, tc;
    logic [4:0]      dec_value;
    logic            illegal;
    logic            capture;
    logic            full;
    logic            pop;
    logic            push;
    logic            drop;

    // Trit decode: 01 -> 0, 11 -> 1, 10 -> 2; 00 is illegal and flagged separately.
    function automatic logic [1:0] trit_val(input logic [1:0] t);
        case (t)
            2'b11:   trit_val = 2'd1;
            2'b10:   trit_val = 2'd2;
            default: trit_val = 2'd0;
        endcase
    endfunction

    always_comb begin
        ta        = trit_val(s_q[5:4]);
        tb        = trit_val(s_q[3:2]);
        tc        = trit_val(s_q[1:0]);
        dec_value = ({3'b000, ta} << 3) + {3'b000, ta}
                  + ({3'b000, tb} << 1) + {3'b000, tb}
                  + {3'b000, tc};
        illegal   = (s_q[5:4] == 2'b00) || (s_q[3:2] == 2'b00) || (s_q[1:0] == 2'b00);
    end

    // Output handshake: the head word is transferred on a rising edge where m_valid && m_ready;
    // m_value/m_raw are stable while m_valid is high and m_valid never depends on m_ready.
    assign capture = (state == CAPTURE);
    assign full    = (level == LEVEL_FULL);
    assign m_valid = (level != 5'd0);
    assign pop     = m_valid && m_ready;
    assign push    = capture && !illegal && (!full || pop);
    assign drop    = capture && !illegal && full && !pop;
    assign cnt_inc = stable_cnt + 4'd1;

    assign m_value    = m_valid ? mem_val[rd_ptr] : 5'd0;
    assign m_raw      = m_valid ? mem_raw[rd_ptr] : 6'd0;
    assign fifo_level = level;
    assign state_dbg  = state;

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state      <= IDLE;
            s_q        <= 6'd0;
            stable_cnt <= 4'd0;
        end else begin
            s_q <= trits_in;
            if (!en) begin
                state      <= IDLE;
                stable_cnt <= 4'd0;
            end else begin
                case (state)
                    IDLE: state <= SETTLE;
                    SETTLE: begin
                        if (trits_in != s_q) begin
                            stable_cnt <= 4'd0;
                        end else begin
                            stable_cnt <= cnt_inc;
                            if (cnt_inc == SETTLE_LAST) state <= CAPTURE;
                        end
                    end
                    CAPTURE: state <= HOLD;
                    HOLD: begin
                        if (trits_in != s_q) begin
                            stable_cnt <= 4'd0;
                            state      <= SETTLE;
                        end
                    end
                    default: state <= IDLE;
                endcase
            end
        end
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            err_count <= 8'd0;
            overflow  <= 1'b0;
        end else begin
            if (capture && illegal && (err_count != 8'hFF)) err_count <= err_count + 8'd1;
            if (drop) overflow <= 1'b1;
        end
    end

    // Pointers wrap naturally because FIFO_DEPTH is a power of two.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            wr_ptr <= '0;
            rd_ptr <= '0;
            level  <= 5'd0;
            for (int i = 0; i < FIFO_DEPTH; i++) begin
                mem_raw[i] <= 6'd0;
                mem_val[i] <= 5'd0;
            end
        end else begin
            if (push) begin
                mem_raw[wr_ptr] <= s_q;
                mem_val[wr_ptr] <= dec_value;
                wr_ptr          <= wr_ptr + PW'(1);
            end
            if (pop) rd_ptr <= rd_ptr + PW'(1);
            case ({push, pop})
                2'b10:   level <= level + 5'd1;
                2'b01:   level <= level - 5'd1;
                default: level <= level;
            endcase
        end
    end

endmodule

// File: tb/tb_ternary_trit_capture.sv
// Directed bench for ternary_trit_capture: expected words queued at stimulus time,
// popped and compared whenever the head is accepted.
module tb_ternary_trit_capture;

    localparam int SC = 4;

    logic       clk;
    logic       rst_n;
    logic       en;
    logic [5:0] trits_in;
    logic       m_valid;
    logic       m_ready;
    logic [4:0] m_value;
    logic [5:0] m_raw;
    logic [4:0] fifo_level;
    logic [7:0] err_count;
    logic       overflow;
    logic [1:0] state_dbg;

    int total = 0;
    int bad = 0;
    int pop_count = 0;
    logic [10:0] exp_q[$];

    ternary_trit_capture #(.SETTLE_CYCLES(SC), .FIFO_DEPTH(4)) dut (
        .clk        (clk),
        .rst_n      (rst_n),
        .en         (en),
        .trits_in   (trits_in),
        .m_valid    (m_valid),
        .m_ready    (m_ready),
        .m_value    (m_value),
        .m_raw      (m_raw),
        .fifo_level (fifo_level),
        .err_count  (err_count),
        .overflow   (overflow),
        .state_dbg  (state_dbg)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        total++;
        assert (obs === exp)
        else begin
            bad++;
            $error("FAIL %s: observed=%0d expected=%0d", tag, obs, exp);
        end
    endtask

    function automatic int tv(input logic [1:0] t);
        if (t == 2'b01) return 0;
        if (t == 2'b11) return 1;
        return 2;
    endfunction

    function automatic logic [4:0] model_value(input logic [5:0] w);
        return 5'(tv(w[5:4]) * 9 + tv(w[3:2]) * 3 + tv(w[1:0]));
    endfunction

    task automatic expect_word(input logic [5:0] w);
        exp_q.push_back({w, model_value(w)});
    endtask

    // Inputs change 2 time units after each rising edge.
    task automatic tick(input int n);
        repeat (n) begin
            @(posedge clk);
            #2;
        end
    endtask

    task automatic drive(input logic [5:0] w, input bit expected, input int n);
        trits_in = w;
        if (expected) expect_word(w);
        tick(n);
    endtask

    always @(negedge clk) begin
        if (rst_n && m_valid && m_ready) begin
            logic [10:0] e;
            pop_count++;
            if (exp_q.size() == 0) begin
                total++;
                bad++;
                $error("FAIL unexpected_word: observed raw=%b expected none", m_raw);
            end else begin
                e = exp_q.pop_front();
                check("head_raw", 32'(m_raw), 32'(e[10:5]));
                check("head_value", 32'(m_value), 32'(e[4:0]));
            end
        end
    end

    initial begin
        rst_n    = 1'b0;
        en       = 1'b0;
        m_ready  = 1'b1;
        trits_in = 6'b010101;
        tick(2);
        check("rst_m_valid", 32'(m_valid), 0);
        check("rst_m_value", 32'(m_value), 0);
        check("rst_m_raw", 32'(m_raw), 0);
        check("rst_level", 32'(fifo_level), 0);
        check("rst_err", 32'(err_count), 0);
        check("rst_overflow", 32'(overflow), 0);
        check("rst_state", 32'(state_dbg), 0);
        rst_n = 1'b1;
        tick(2);

        // Legal decode
        en = 1'b1;
        expect_word(6'b010101);
        tick(10);
        check("single_capture", pop_count, 1);
        drive(6'b110101, 1, 10);
        drive(6'b101110, 1, 10);
        drive(6'b101010, 1, 10);
        check("legal_count", pop_count, 4);

        // Illegal word
        drive(6'b000101, 0, 10);
        check("illegal_err", 32'(err_count), 1);
        check("illegal_no_valid", 32'(m_valid), 0);
        check("illegal_no_pop", pop_count, 4);
        drive(6'b011101, 1, 10);
        check("after_illegal_err", 32'(err_count), 1);
        check("after_illegal_pop", pop_count, 5);

        // Glitch shorter than the settle window
        drive(6'b010101, 1, 10);
        drive(6'b111111, 0, SC - 1);
        drive(6'b010101, 1, 10);
        check("glitch_pop", pop_count, 7);

        // Overflow with consumer stalled
        m_ready = 1'b0;
        drive(6'b110101, 1, 8);
        drive(6'b101110, 1, 8);
        drive(6'b101010, 1, 8);
        drive(6'b011101, 1, 8);
        drive(6'b111111, 0, 8);
        check("ovf_level", 32'(fifo_level), 4);
        check("ovf_flag", 32'(overflow), 1);
        check("ovf_valid", 32'(m_valid), 1);
        m_ready = 1'b1;
        tick(6);
        check("ovf_drain_level", 32'(fifo_level), 0);
        check("ovf_drain_pop", pop_count, 11);

        // Reset mid-SETTLE with two entries queued
        m_ready = 1'b0;
        drive(6'b110101, 0, 8);
        drive(6'b101110, 0, 8);
        check("pre_rst_level", 32'(fifo_level), 2);
        check("pre_rst_err", 32'(err_count), 1);
        check("pre_rst_ovf", 32'(overflow), 1);
        drive(6'b101010, 0, 2);
        rst_n = 1'b0;
        #1;
        check("arst_m_valid", 32'(m_valid), 0);
        check("arst_level", 32'(fifo_level), 0);
        check("arst_m_value", 32'(m_value), 0);
        check("arst_m_raw", 32'(m_raw), 0);
        check("arst_err", 32'(err_count), 0);
        check("arst_ovf", 32'(overflow), 0);
        check("arst_state", 32'(state_dbg), 0);
        tick(2);
        rst_n = 1'b1;
        expect_word(6'b101010);
        m_ready = 1'b1;
        tick(10);
        check("post_rst_pop", pop_count, 12);
        check("post_rst_level", 32'(fifo_level), 0);

        // Full FIFO with a pop exactly on the fifth CAPTURE cycle
        m_ready = 1'b0;
        drive(6'b110101, 1, 8);
        drive(6'b101110, 1, 8);
        drive(6'b011101, 1, 8);
        drive(6'b111111, 1, 8);
        check("full_level", 32'(fifo_level), 4);
        drive(6'b010101, 1, 5);
        m_ready = 1'b1;
        tick(1);
        m_ready = 1'b0;
        tick(2);
        check("pulse_ovf", 32'(overflow), 0);
        check("pulse_level", 32'(fifo_level), 4);
        m_ready = 1'b1;
        tick(6);
        check("pulse_drain_level", 32'(fifo_level), 0);
        check("pulse_drain_pop", pop_count, 17);

        // Enable-driven capture latency
        m_ready  = 1'b0;
        en       = 1'b0;
        trits_in = 6'b111111;
        tick(4);
        check("en_low_state", 32'(state_dbg), 0);
        check("en_low_level", 32'(fifo_level), 0);
        en = 1'b1;
        tick(SC + 1);
        check("lat_before", 32'(m_valid), 0);
        tick(1);
        check("lat_valid", 32'(m_valid), 1);
        check("lat_value", 32'(m_value), 13);
        check("lat_raw", 32'(m_raw), 32'(6'b111111));
        expect_word(6'b111111);
        m_ready = 1'b1;
        tick(3);
        check("final_pop", pop_count, 18);
        check("final_level", 32'(fifo_level), 0);
        check("queue_empty", exp_q.size(), 0);

        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

endmodule
